// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the mul_top ap_ctrl_hs arbiter.
// Optional statistics counters are enabled with `define MUL_ARB_STATS_EN.
package mul_arb_pkg;

  localparam int STAT_W = 32;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE
  } state_e;

  // Tag width for n requesters, never below one bit.
  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_arb_tag_fifo.sv
// In-order FIFO of requester tags for transactions the kernel has accepted.
// Simultaneous push and pop is legal whenever the FIFO is non-empty.
module mul_arb_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occ == '0);
  assign full    = (occ == FULL_OCC);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // The outstanding-count reservation upstream must make this unreachable.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/mul_top_ap_arbiter.sv
// Round-robin sharing of one ap_ctrl_hs mul_top kernel between N_REQ requesters.
// `define MUL_ARB_STATS_EN adds the stat_txn / stat_stall counters.
module mul_top_ap_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int RET_W   = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*DATA_W-1:0]        req_a,
  input  logic [N_REQ*DATA_W-1:0]        req_b,
  output logic [N_REQ-1:0]               rsp_valid,
  input  logic [N_REQ-1:0]               rsp_ready,
  output logic [RET_W-1:0]               rsp_data,
  output logic                           ap_start,
  input  logic                           ap_ready,
  input  logic                           ap_done,
  output logic                           ap_continue,
  output logic [DATA_W-1:0]              a,
  output logic [DATA_W-1:0]              b,
  input  logic [RET_W-1:0]               ap_return,
  output logic                           err,
  output state_e                         dbg_state,
  output logic [$clog2(MAX_OUT+1)-1:0]   dbg_count
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]              stat_txn,
  output logic [STAT_W-1:0]              stat_stall
`endif
);

  // Handshakes: a request transfers in the cycle req_valid[i] && req_ready[i];
  // the kernel takes operands when ap_start && ap_ready, and a result retires
  // when ap_done && ap_continue, which is only raised while rsp_ready[owner] is high.

  localparam int TAG_W = tag_w(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(N_REQ - 1);

  state_e             state;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   win;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   head_tag;
  logic [CNT_W-1:0]   count;
  logic               found;
  logic               grant;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win   = TAG_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign grant = (state == IDLE) && found && (count < CNT_MAX);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (ap_done && !fifo_empty) rsp_valid[head_tag] = 1'b1;
  end

  // With nothing in flight a stray ap_done is acknowledged so the kernel cannot hang.
  assign ap_continue = fifo_empty ? ap_done : rsp_ready[head_tag];
  assign rsp_data    = ap_return;
  assign ap_start    = (state == ISSUE);
  assign push        = (state == ISSUE) && ap_ready;
  assign pop         = ap_done && !fifo_empty && rsp_ready[head_tag];
  assign dbg_state   = state;
  assign dbg_count   = count;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      tag_q  <= '0;
      a      <= '0;
      b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            a      <= req_a[win*DATA_W +: DATA_W];
            b      <= req_b[win*DATA_W +: DATA_W];
            tag_q  <= win;
            rr_ptr <= (win == LAST_REQ) ? '0 : win + 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (ap_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A slot is reserved at grant so the FIFO can never overflow.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count <= '0;
    end else begin
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err <= 1'b0;
    end else if ((ap_done && fifo_empty) || (ap_ready && state != ISSUE) ||
                 (push && fifo_full && !pop)) begin
      err <= 1'b1;
    end
  end

  mul_arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (push),
    .din   (tag_q),
    .pop   (pop),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (head_tag)
  );

`ifdef MUL_ARB_STATS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_txn   <= '0;
      stat_stall <= '0;
    end else begin
      if (pop) stat_txn <= stat_txn + 1'b1;
      if (ap_done && !ap_continue) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule
